// File: rtl/kernel_request_arbiter_if.sv
// Requester and kernel-generator signals shared by kernel_request_arbiter.
// The slave modport is the arbiter; the master modport is its environment
// (the filter-stage requesters together with the kernel generator).
interface kernel_request_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned SIGMA_W = 3;

  logic [NREQ-1:0]              req;
  logic [NREQ-1:0][SIGMA_W-1:0] req_sigma;
  logic [NREQ-1:0]              grant;
  logic [NREQ-1:0]              ack;
  logic                         ack_err;
  logic                         busy;
  logic                         kern_start;
  logic [SIGMA_W-1:0]           kern_sigma;
  logic                         kern_done;
  logic                         kern_err;

  modport slave (
    input  req, req_sigma, kern_done, kern_err,
    output grant, ack, ack_err, busy, kern_start, kern_sigma
  );

  modport master (
    output req, req_sigma, kern_done, kern_err,
    input  grant, ack, ack_err, busy, kern_start, kern_sigma
  );
endinterface

// File: rtl/kernel_request_arbiter.sv
// kernel_request_arbiter: shares one Gaussian kernel generator between NREQ
// requesters. Round-robin pick in IDLE, one-cycle launch, supervised wait
// with a timeout, then a one-cycle acknowledge carrying an error status.
// Optional feature: define KERNEL_CACHE_EN to keep the sigma of the last
// successful build and answer a repeat request without relaunching.
module kernel_request_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                     clk,
  input logic                     n_rst,
  kernel_request_arbiter_if.slave bus
);

  localparam int unsigned SIGMA_W = 3;
  localparam int unsigned IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SIGMA_W-1:0]  sigma_q, sigma_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_sticky_q, err_sticky_d;
  logic                status_q, status_d;

  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                ack_err_q, ack_err_d;
  logic                busy_q, busy_d;
  logic                kern_start_q, kern_start_d;
  logic [SIGMA_W-1:0]  kern_sigma_q, kern_sigma_d;

`ifdef KERNEL_CACHE_EN
  logic                cache_valid_q, cache_valid_d;
  logic [SIGMA_W-1:0]  cache_sigma_q, cache_sigma_d;
`endif

  logic                win_found_c;
  logic [IDXW-1:0]     win_idx_c;
  logic [IDXW-1:0]     cand_c;

  // Round-robin search: first set request bit at or above rr_ptr, wrapping.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(rr_ptr_q) + i >= NREQ) begin
        cand_c = IDXW'(32'(rr_ptr_q) + i - NREQ);
      end else begin
        cand_c = IDXW'(32'(rr_ptr_q) + i);
      end
      if (!win_found_c && bus.req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // Next-state, supervision and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rr_ptr_d     = rr_ptr_q;
    sigma_d      = sigma_q;
    timer_d      = timer_q;
    err_sticky_d = err_sticky_q;
    status_d     = status_q;
`ifdef KERNEL_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_sigma_d = cache_sigma_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (win_found_c) begin
          idx_d   = win_idx_c;
          sigma_d = bus.req_sigma[win_idx_c];
          state_d = LAUNCH;
`ifdef KERNEL_CACHE_EN
          // A repeat of the last good sigma needs no generator run.
          if (cache_valid_q && (bus.req_sigma[win_idx_c] == cache_sigma_q)) begin
            status_d = 1'b0;
            state_d  = RESP;
          end
`endif
        end
      end

      LAUNCH: begin
        err_sticky_d = 1'b0;
        timer_d      = '0;
        state_d      = WAIT;
      end

      WAIT: begin
        err_sticky_d = err_sticky_q | bus.kern_err;
        if (bus.kern_done) begin
          // Completion beats a timeout landing on the same cycle.
          status_d = err_sticky_q | bus.kern_err;
          state_d  = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          status_d = 1'b1;
          state_d  = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      RESP: begin
        rr_ptr_d = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + IDXW'(1);
        state_d  = IDLE;
`ifdef KERNEL_CACHE_EN
        cache_valid_d = !status_q;
        cache_sigma_d = sigma_q;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    grant_d      = '0;
    ack_d        = '0;
    ack_err_d    = 1'b0;
    busy_d       = (state_d != IDLE);
    kern_start_d = (state_d == LAUNCH);
    kern_sigma_d = (state_d == LAUNCH) ? sigma_d : kern_sigma_q;
    if (state_d != IDLE) begin
      grant_d[idx_d] = 1'b1;
    end
    if (state_d == RESP) begin
      ack_d[idx_d] = 1'b1;
      ack_err_d    = status_d;
    end
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rr_ptr_q     <= '0;
      sigma_q      <= '0;
      timer_q      <= '0;
      err_sticky_q <= 1'b0;
      status_q     <= 1'b0;
      grant_q      <= '0;
      ack_q        <= '0;
      ack_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      kern_start_q <= 1'b0;
      kern_sigma_q <= '0;
`ifdef KERNEL_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_sigma_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rr_ptr_q     <= rr_ptr_d;
      sigma_q      <= sigma_d;
      timer_q      <= timer_d;
      err_sticky_q <= err_sticky_d;
      status_q     <= status_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      ack_err_q    <= ack_err_d;
      busy_q       <= busy_d;
      kern_start_q <= kern_start_d;
      kern_sigma_q <= kern_sigma_d;
`ifdef KERNEL_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_sigma_q <= cache_sigma_d;
`endif
    end
  end

  assign bus.grant      = grant_q;
  assign bus.ack        = ack_q;
  assign bus.ack_err    = ack_err_q;
  assign bus.busy       = busy_q;
  assign bus.kern_start = kern_start_q;
  assign bus.kern_sigma = kern_sigma_q;

endmodule

// File: tb/tb_kernel_request_arbiter.sv
// Scoreboard bench for kernel_request_arbiter: the stimulus thread pushes
// expected launches, acknowledges and output snapshots; a negedge monitor
// pops and compares them. Expectations follow the cache build when
// KERNEL_CACHE_EN is defined.
module tb_kernel_request_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int L       = 3;

`ifdef KERNEL_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  typedef struct { int cyc; logic [NREQ-1:0] ack; logic err; } ack_t;
  typedef struct { int cyc; logic [2:0] sigma; } start_t;
  typedef struct {
    int              cyc;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic [NREQ-1:0] ack;
    logic            start;
    logic            full;
  } snap_t;

  logic clk;
  logic n_rst;
  int   cyc = 0;

  int   checks = 0;
  int   errors = 0;
  bit   end_of_test = 1'b0;

  ack_t   ack_q[$];
  start_t start_q[$];
  snap_t  snap_q[$];

  int   gen_lat     = 1;
  int   gen_err_off = 0;
  bit   gen_mute    = 1'b0;
  bit   gen_busy    = 1'b0;
  int   gen_t0      = 0;
  bit   auto_drop   = 1'b1;
  int   x_done_cyc  = -1;
  int   x_err_cyc   = -1;
  int   x_err2_cyc  = -1;

  kernel_request_arbiter_if #(.NREQ(NREQ)) bus ();

  kernel_request_arbiter #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NREQ-1:0] oh(input logic [1:0] i);
    return NREQ'(1) << i;
  endfunction

  function automatic void push_ack(input int c, input logic [NREQ-1:0] v, input logic e);
    ack_t x;
    int   k;
    x.cyc = c; x.ack = v; x.err = e;
    k = 0;
    while (k < ack_q.size() && ack_q[k].cyc <= c) k++;
    ack_q.insert(k, x);
  endfunction

  function automatic void push_start(input int c, input logic [2:0] s);
    start_t x;
    int     k;
    x.cyc = c; x.sigma = s;
    k = 0;
    while (k < start_q.size() && start_q[k].cyc <= c) k++;
    start_q.insert(k, x);
  endfunction

  function automatic void push_snap(input int c, input logic [NREQ-1:0] g, input logic b,
                                    input logic [NREQ-1:0] a, input logic st, input logic full);
    snap_t x;
    int    k;
    x.cyc = c; x.grant = g; x.busy = b; x.ack = a; x.start = st; x.full = full;
    k = 0;
    while (k < snap_q.size() && snap_q[k].cyc <= c) k++;
    snap_q.insert(k, x);
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Monitor: compares DUT outputs against the scoreboard queues.
  ack_t   ae;
  start_t se;
  snap_t  sn;
  always @(negedge clk) begin
    while (snap_q.size() != 0 && snap_q[0].cyc == cyc) begin
      sn = snap_q.pop_front();
      chk("snap_grant", 32'(bus.grant), 32'(sn.grant));
      chk("snap_busy", 32'(bus.busy), 32'(sn.busy));
      chk("snap_ack", 32'(bus.ack), 32'(sn.ack));
      chk("snap_kern_start", 32'(bus.kern_start), 32'(sn.start));
      if (sn.full) begin
        chk("snap_ack_err", 32'(bus.ack_err), 32'd0);
        chk("snap_kern_sigma", 32'(bus.kern_sigma), 32'd0);
      end
    end
    if (n_rst) begin
      if (bus.ack != '0) begin
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", 32'(bus.ack), 32'd0);
        end else begin
          ae = ack_q.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(ae.cyc));
          chk("ack_vec", 32'(bus.ack), 32'(ae.ack));
          chk("ack_err", 32'(bus.ack_err), 32'(ae.err));
        end
      end else if (ack_q.size() != 0 && ack_q[0].cyc <= cyc) begin
        ae = ack_q.pop_front();
        chk("ack_missing", 32'(bus.ack), 32'(ae.ack));
      end
      if (bus.kern_start) begin
        if (start_q.size() == 0) begin
          chk("start_unexpected", 32'(bus.kern_start), 32'd0);
        end else begin
          se = start_q.pop_front();
          chk("start_cycle", 32'(cyc), 32'(se.cyc));
          chk("start_sigma", 32'(bus.kern_sigma), 32'(se.sigma));
        end
      end else if (start_q.size() != 0 && start_q[0].cyc <= cyc) begin
        se = start_q.pop_front();
        chk("start_missing", 32'(bus.kern_start), 32'd1);
      end
    end
    if (end_of_test) begin
      chk("ack_leftover", 32'(ack_q.size()), 32'd0);
      chk("start_leftover", 32'(start_q.size()), 32'd0);
      chk("snap_leftover", 32'(snap_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // One clock of stimulus: requester drop-after-ack plus generator model.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.kern_done = 1'b0;
    bus.kern_err  = 1'b0;
    if (auto_drop) bus.req = bus.req & ~bus.ack;
    if (bus.kern_start) begin
      gen_t0   = cyc;
      gen_busy = !gen_mute;
    end
    if (gen_busy && cyc == gen_t0 + gen_lat) begin
      bus.kern_done = 1'b1;
      gen_busy      = 1'b0;
    end
    if (gen_busy && gen_err_off > 0 && cyc == gen_t0 + gen_err_off) bus.kern_err = 1'b1;
    if (cyc == x_done_cyc) bus.kern_done = 1'b1;
    if (cyc == x_err_cyc || cyc == x_err2_cyc) bus.kern_err = 1'b1;
  endtask

  // Single request from an idle arbiter; returns on the IDLE cycle after ack.
  task automatic request(input logic [1:0] r, input logic [2:0] sig, input int lat,
                         input int err_off, input bit mute, input bit hit, input bit exp_err);
    int s;
    int a;
    gen_lat     = lat;
    gen_err_off = err_off;
    gen_mute    = mute;
    s = cyc;
    bus.req_sigma[r] = sig;
    bus.req[r]       = 1'b1;
    if (hit) begin
      a = s + 1;
    end else begin
      push_start(s + 1, sig);
      a = mute ? s + 2 + TIMEOUT : s + 2 + lat;
    end
    push_ack(a, oh(r), exp_err);
    push_snap(s + 1, oh(r), 1'b1, hit ? oh(r) : '0, !hit, 1'b0);
    if (a != s + 1) push_snap(a, oh(r), 1'b1, oh(r), 1'b0, 1'b0);
    push_snap(a + 1, '0, 1'b0, '0, 1'b0, 1'b0);
    while (cyc < a + 1) tick();
  endtask

  logic [2:0] rr_sig [NREQ];

  initial begin : stim
    int s;
    int s0;
    n_rst         = 1'b0;
    bus.req       = '0;
    bus.req_sigma = '0;
    bus.kern_done = 1'b0;
    bus.kern_err  = 1'b0;

    // Reset values
    tick();
    push_snap(cyc, '0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    n_rst = 1'b1;
    tick();

    // Single request: requester 2, sigma 3, done 12 cycles after start
    push_snap(cyc + 8, 4'b0100, 1'b1, '0, 1'b0, 1'b0);
    request(2'd2, 3'd3, 12, 0, 1'b0, 1'b0, 1'b0);

    // Reset in WAIT abandons the build; requester 0 is served first after
    gen_mute = 1'b1;
    s = cyc;
    bus.req_sigma[1] = 3'd6;
    bus.req[1]       = 1'b1;
    push_start(s + 1, 3'd6);
    push_snap(s + 2, 4'b0010, 1'b1, '0, 1'b0, 1'b0);
    repeat (3) tick();
    n_rst = 1'b0;
    push_snap(cyc, '0, 1'b0, '0, 1'b0, 1'b1);
    rr_sig[0] = 3'd1; rr_sig[1] = 3'd6; rr_sig[2] = 3'd4; rr_sig[3] = 3'd7;
    for (int k = 0; k < NREQ; k++) bus.req_sigma[k] = rr_sig[k];
    bus.req = 4'b1111;
    tick();
    push_snap(cyc, '0, 1'b0, '0, 1'b0, 1'b1);
    n_rst       = 1'b1;
    gen_mute    = 1'b0;
    gen_lat     = L;
    gen_err_off = 0;

    // Round robin with all four held: 0,1,2,3
    s0 = cyc;
    for (int k = 0; k < NREQ; k++) begin
      push_start(s0 + k * (L + 3) + 1, rr_sig[k]);
      push_snap(s0 + k * (L + 3) + 1, oh(2'(k)), 1'b1, '0, 1'b1, 1'b0);
      push_ack(s0 + k * (L + 3) + 2 + L, oh(2'(k)), 1'b0);
    end
    while (cyc < s0 + NREQ * (L + 3)) tick();

    // rr_ptr back at 0, req=1010: 1 then 3
    s = cyc;
    bus.req_sigma[1] = 3'd2;
    bus.req_sigma[3] = 3'd0;
    bus.req          = 4'b1010;
    push_start(s + 1, 3'd2);
    push_ack(s + 2 + L, 4'b0010, 1'b0);
    push_start(s + L + 4, 3'd0);
    push_snap(s + L + 4, 4'b1000, 1'b1, '0, 1'b1, 1'b0);
    push_ack(s + 2 * L + 5, 4'b1000, 1'b0);
    while (cyc < s + 2 * (L + 3)) tick();

    // Generator error pulse mid-WAIT
    request(2'd0, 3'd4, 6, 3, 1'b0, 1'b0, 1'b1);

    // kern_err in IDLE and LAUNCH is ignored
    x_err_cyc  = cyc + 1;
    x_err2_cyc = cyc + 2;
    tick();
    request(2'd2, 3'd2, 4, 0, 1'b0, 1'b0, 1'b0);

    // Done on the last WAIT cycle beats the timeout
    request(2'd1, 3'd6, TIMEOUT, 0, 1'b0, 1'b0, 1'b0);

    // Done on the first WAIT cycle
    request(2'd0, 3'd1, 1, 0, 1'b0, 1'b0, 1'b0);

    // Timeout, then a late done while IDLE is ignored
    request(2'd3, 3'd5, 0, 0, 1'b1, 1'b0, 1'b1);
    x_done_cyc = cyc + 1;
    push_snap(cyc + 2, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (4) tick();
    gen_mute = 1'b0;

    // Repeat sigma: cached answer when enabled, otherwise a normal build
    request(2'd0, 3'd5, 2, 0, 1'b0, 1'b0, 1'b0);
    request(2'd0, 3'd5, 2, 0, 1'b0, CACHE_ON, 1'b0);
    request(2'd1, 3'd1, 2, 0, 1'b0, 1'b0, 1'b0);
    request(2'd2, 3'd5, 3, 1, 1'b0, 1'b0, 1'b1);
    request(2'd3, 3'd5, 2, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) tick();
    end_of_test = 1'b1;
    repeat (5) tick();
    $display("FAIL summary_not_reached: got none expected summary");
    $fatal(1);
  end

endmodule
